// File: rtl/npcg_toggle_bcmd_pkg.sv
// Shared definitions for the NPCG_Toggle blocking-command scheduler:
// state encoding, opcode decode constants, PM slice layout and idle constants.
package npcg_toggle_bcmd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_RUN   = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERR   = 3'd4
  } state_e;

  localparam logic [5:0] OPC_NOP           = 6'b000000;
  localparam logic [2:0] OPC_ENGINE_PREFIX = 3'b100;

  // Per-engine PM slice: {PCommand[7:0], PCommandOption[2:0], NumOfData[15:0]}
  localparam int unsigned PM_SLICE_W     = 27;
  localparam int unsigned PM_NUMDATA_LSB = 0;
  localparam int unsigned PM_NUMDATA_W   = 16;
  localparam int unsigned PM_OPTION_LSB  = 16;
  localparam int unsigned PM_OPTION_W    = 3;
  localparam int unsigned PM_PCMD_LSB    = 19;
  localparam int unsigned PM_PCMD_W      = 8;

  localparam logic [7:0]  IDLE_PCOMMAND        = 8'h00;
  localparam logic [2:0]  IDLE_PCOMMAND_OPTION = 3'b000;
  localparam logic [15:0] IDLE_NUM_OF_DATA     = 16'h1234;

endpackage

// File: rtl/npcg_toggle_bcmd_pm_mux.sv
// Selects and unpacks the granted engine's PM slice, or drives the idle
// constants when no engine holds the grant.
module npcg_toggle_bcmd_pm_mux
  import npcg_toggle_bcmd_pkg::*;
#(
  parameter int unsigned NumberOfWays    = 4,
  parameter int unsigned NumberOfEngines = 4
) (
  input  logic                                  grant,
  input  logic [2:0]                            index,
  input  logic [NumberOfWays-1:0]               way,
  input  logic [NumberOfEngines*PM_SLICE_W-1:0] bus,
  output logic [7:0]                            pcommand_c,
  output logic [2:0]                            option_c,
  output logic [NumberOfWays-1:0]               target_way_c,
  output logic [15:0]                           num_of_data_c
);

  logic [PM_SLICE_W-1:0] slice;

  always_comb begin
    slice = '0;
    for (int e = 0; e < int'(NumberOfEngines); e++) begin
      if (index == 3'(e)) slice = bus[e*PM_SLICE_W +: PM_SLICE_W];
    end
  end

  always_comb begin
    pcommand_c    = IDLE_PCOMMAND;
    option_c      = IDLE_PCOMMAND_OPTION;
    target_way_c  = '0;
    num_of_data_c = IDLE_NUM_OF_DATA;
    if (grant) begin
      pcommand_c    = slice[PM_PCMD_LSB +: PM_PCMD_W];
      option_c      = slice[PM_OPTION_LSB +: PM_OPTION_W];
      target_way_c  = way;
      num_of_data_c = slice[PM_NUMDATA_LSB +: PM_NUMDATA_W];
    end
  end

endmodule

// File: rtl/npcg_toggle_bcmd_scheduler.sv
// Blocking-command scheduler: decodes one command at a time to an engine,
// pulses its start and grants it the PM bus until its last step.
// Optional RUN watchdog is built when NPCG_BCMD_WATCHDOG_EN is defined.
module npcg_toggle_bcmd_scheduler
  import npcg_toggle_bcmd_pkg::*;
#(
  parameter int unsigned NumberOfWays    = 4,
  parameter int unsigned NumberOfEngines = 4,
  parameter int unsigned WatchdogLimit   = 32'h0000_FFFF
) (
  input  logic                                  iSystemClock,
  input  logic                                  iReset,
  input  logic                                  iCMDValid,
  output logic                                  oCMDReady,
  input  logic [5:0]                            iOpcode,
  input  logic [NumberOfWays-1:0]               iTargetWay,
  output logic [NumberOfEngines-1:0]            oEngineStart,
  input  logic [NumberOfEngines-1:0]            iEngineLastStep,
  input  logic [NumberOfEngines*PM_SLICE_W-1:0] iEnginePMBus,
  output logic [7:0]                            oPM_PCommand,
  output logic [2:0]                            oPM_PCommandOption,
  output logic [NumberOfWays-1:0]               oPM_TargetWay,
  output logic [15:0]                           oPM_NumOfData,
  output logic                                  oCMDDone,
  output logic                                  oCMDError,
  output logic                                  oCMDTimeout,
  output logic [15:0]                           oCMDCount
);

  if (NumberOfEngines < 1 || NumberOfEngines > 8 ||
      WatchdogLimit < 1 || WatchdogLimit > 32'h0000_FFFF) begin : g_param_check
    $error("npcg_toggle_bcmd_scheduler: parameter out of range");
  end

  state_e                     state, state_next;
  logic [2:0]                 index_q;
  logic [NumberOfWays-1:0]    way_q;
  logic [NumberOfEngines-1:0] start_onehot_c;
  logic [NumberOfEngines-1:0] sel_onehot_c;
  logic                       last_step_c;
  logic                       engine_op_c;
  logic                       accept_c;
  logic                       wd_hit_c;
  logic                       grant_c;

  always_comb begin
    start_onehot_c = '0;
    sel_onehot_c   = '0;
    for (int e = 0; e < int'(NumberOfEngines); e++) begin
      start_onehot_c[e] = (iOpcode[2:0] == 3'(e));
      sel_onehot_c[e]   = (index_q == 3'(e));
    end
  end

  // Only the granted engine's last step can end RUN.
  assign last_step_c = |(iEngineLastStep & sel_onehot_c);
  assign accept_c    = (state == ST_IDLE) && iCMDValid;
  assign engine_op_c = (iOpcode[5:3] == OPC_ENGINE_PREFIX) &&
                       ({1'b0, iOpcode[2:0]} < 4'(NumberOfEngines));
  assign grant_c     = (state == ST_START) || (state == ST_RUN);

`ifdef NPCG_BCMD_WATCHDOG_EN
  logic [15:0] wd_cnt;

  // Cleared while in START so RUN always begins counting from zero.
  always_ff @(posedge iSystemClock or posedge iReset) begin
    if (iReset)                 wd_cnt <= '0;
    else if (state == ST_START) wd_cnt <= '0;
    else if (state == ST_RUN)   wd_cnt <= wd_cnt + 16'd1;
  end

  assign wd_hit_c = (state == ST_RUN) && (wd_cnt == 16'(WatchdogLimit - 1));

  always_ff @(posedge iSystemClock or posedge iReset) begin
    if (iReset) oCMDTimeout <= 1'b0;
    else        oCMDTimeout <= wd_hit_c && !last_step_c;
  end
`else
  assign wd_hit_c    = 1'b0;
  assign oCMDTimeout = 1'b0;
`endif

  always_ff @(posedge iSystemClock or posedge iReset) begin
    if (iReset) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE: begin
        if (iCMDValid) begin
          if (iOpcode == OPC_NOP) state_next = ST_DONE;
          else if (engine_op_c)   state_next = ST_START;
          else                    state_next = ST_ERR;
        end
      end
      ST_START: state_next = ST_RUN;
      ST_RUN: begin
        if (last_step_c)   state_next = ST_DONE;
        else if (wd_hit_c) state_next = ST_IDLE;
      end
      ST_DONE: state_next = ST_IDLE;
      ST_ERR:  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Latched command fields and registered status outputs.
  always_ff @(posedge iSystemClock or posedge iReset) begin
    if (iReset) begin
      index_q      <= '0;
      way_q        <= '0;
      oCMDReady    <= 1'b1;
      oCMDDone     <= 1'b0;
      oCMDError    <= 1'b0;
      oEngineStart <= '0;
      oCMDCount    <= '0;
    end else begin
      if (accept_c) begin
        index_q <= iOpcode[2:0];
        way_q   <= iTargetWay;
      end
      oCMDReady    <= (state_next == ST_IDLE);
      oCMDDone     <= (state_next == ST_DONE);
      oCMDError    <= (state_next == ST_ERR);
      oEngineStart <= (state_next == ST_START) ? start_onehot_c : '0;
      if (state_next == ST_DONE) oCMDCount <= oCMDCount + 16'd1;
    end
  end

  npcg_toggle_bcmd_pm_mux #(
    .NumberOfWays   (NumberOfWays),
    .NumberOfEngines(NumberOfEngines)
  ) u_pm_mux (
    .grant        (grant_c),
    .index        (index_q),
    .way          (way_q),
    .bus          (iEnginePMBus),
    .pcommand_c   (oPM_PCommand),
    .option_c     (oPM_PCommandOption),
    .target_way_c (oPM_TargetWay),
    .num_of_data_c(oPM_NumOfData)
  );

endmodule

// File: tb/tb_npcg_toggle_bcmd_scheduler.sv
// Directed self-checking bench for npcg_toggle_bcmd_scheduler; the watchdog
// scenario follows NPCG_BCMD_WATCHDOG_EN the same way the design does.
module tb_npcg_toggle_bcmd_scheduler;

  localparam int unsigned WAYS = 4;
  localparam int unsigned ENG  = 4;
  localparam int unsigned SW   = 27;

  logic              clk = 1'b0;
  logic              rst;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [5:0]        opcode;
  logic [WAYS-1:0]   target_way;
  logic [ENG-1:0]    engine_start;
  logic [ENG-1:0]    last_step;
  logic [ENG*SW-1:0] pm_bus;
  logic [7:0]        pm_pcommand;
  logic [2:0]        pm_option;
  logic [WAYS-1:0]   pm_way;
  logic [15:0]       pm_num;
  logic              cmd_done;
  logic              cmd_error;
  logic              cmd_timeout;
  logic [15:0]       cmd_count;

  int errors = 0;
  int checks = 0;
  logic [15:0] exp_count = 16'h0000;

  always #5 clk = ~clk;

  npcg_toggle_bcmd_scheduler #(
    .NumberOfWays   (WAYS),
    .NumberOfEngines(ENG),
    .WatchdogLimit  (8)
  ) dut (
    .iSystemClock      (clk),
    .iReset            (rst),
    .iCMDValid         (cmd_valid),
    .oCMDReady         (cmd_ready),
    .iOpcode           (opcode),
    .iTargetWay        (target_way),
    .oEngineStart      (engine_start),
    .iEngineLastStep   (last_step),
    .iEnginePMBus      (pm_bus),
    .oPM_PCommand      (pm_pcommand),
    .oPM_PCommandOption(pm_option),
    .oPM_TargetWay     (pm_way),
    .oPM_NumOfData     (pm_num),
    .oCMDDone          (cmd_done),
    .oCMDError         (cmd_error),
    .oCMDTimeout       (cmd_timeout),
    .oCMDCount         (cmd_count)
  );

  // Advance one clock and land 1 time unit after the edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; cmd_valid = 1'b0; opcode = '0; target_way = '0; last_step = '0;
    for (int e = 0; e < int'(ENG); e++)
      pm_bus[e*SW +: SW] = {8'hA0 + 8'(e), 3'(e + 1), 16'h1000 + 16'(e)};
    tick; tick;
    rst = 1'b0;
    tick;
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", cmd_ready); end
    checks++; if (pm_num !== 16'h1234) begin errors++; $display("FAIL reset_numdata got=%h exp=1234", pm_num); end
    checks++; if (pm_pcommand !== 8'h00) begin errors++; $display("FAIL reset_pcmd got=%h exp=00", pm_pcommand); end
    checks++; if (cmd_count !== 16'h0000) begin errors++; $display("FAIL reset_count got=%h exp=0000", cmd_count); end
    checks++; if ({engine_start, cmd_done, cmd_error, cmd_timeout} !== 7'b0) begin
      errors++; $display("FAIL reset_pulses got=%b exp=0000000", {engine_start, cmd_done, cmd_error, cmd_timeout}); end
    checks++; if ({pm_way, pm_option} !== 7'b0) begin errors++; $display("FAIL reset_pm_way_opt got=%b exp=0", {pm_way, pm_option}); end
  endtask

  task automatic test_engine_cmd;
    opcode = 6'b100010; target_way = 4'b0100; cmd_valid = 1'b1;
    tick; // T+1: START
    cmd_valid = 1'b0;
    checks++; if (engine_start !== 4'b0100) begin errors++; $display("FAIL eng_start got=%b exp=0100", engine_start); end
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL eng_ready_busy got=%b exp=0", cmd_ready); end
    checks++; if ({pm_pcommand, pm_option, pm_num} !== {8'hA2, 3'd3, 16'h1002}) begin
      errors++; $display("FAIL eng_pm_slice got=%h/%h/%h exp=a2/3/1002", pm_pcommand, pm_option, pm_num); end
    checks++; if (pm_way !== 4'b0100) begin errors++; $display("FAIL eng_pm_way got=%b exp=0100", pm_way); end
    tick; // T+2: RUN
    checks++; if (engine_start !== 4'b0000) begin errors++; $display("FAIL eng_start_once got=%b exp=0000", engine_start); end
    tick; tick; tick; // T+5
    checks++; if (pm_pcommand !== 8'hA2) begin errors++; $display("FAIL eng_grant_held got=%h exp=a2", pm_pcommand); end
    last_step = 4'b0100;
    tick; // T+6
    last_step = '0;
    checks++; if (cmd_done !== 1'b1) begin errors++; $display("FAIL eng_done got=%b exp=1", cmd_done); end
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL eng_ready_in_done got=%b exp=0", cmd_ready); end
    tick; // T+7
    exp_count = exp_count + 16'd1;
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL eng_ready_back got=%b exp=1", cmd_ready); end
    checks++; if (cmd_count !== exp_count) begin errors++; $display("FAIL eng_count got=%h exp=%h", cmd_count, exp_count); end
    checks++; if ({cmd_done, pm_pcommand, pm_num} !== {1'b0, 8'h00, 16'h1234}) begin
      errors++; $display("FAIL eng_idle_pm got=%b/%h/%h exp=0/00/1234", cmd_done, pm_pcommand, pm_num); end
  endtask

  task automatic test_foreign_laststep;
    opcode = 6'b100001; target_way = 4'b0011; cmd_valid = 1'b1;
    tick; cmd_valid = 1'b0; // START
    tick;                   // RUN
    last_step = 4'b1000; cmd_valid = 1'b1; opcode = 6'b000000;
    tick;
    last_step = '0; cmd_valid = 1'b0;
    checks++; if ({cmd_done, cmd_ready, cmd_error} !== 3'b000) begin
      errors++; $display("FAIL foreign_ignored got=%b exp=000", {cmd_done, cmd_ready, cmd_error}); end
    checks++; if ({pm_pcommand, pm_way} !== {8'hA1, 4'b0011}) begin
      errors++; $display("FAIL foreign_grant got=%h/%b exp=a1/0011", pm_pcommand, pm_way); end
    last_step = 4'b0010;
    tick;
    last_step = '0;
    checks++; if (cmd_done !== 1'b1) begin errors++; $display("FAIL foreign_done got=%b exp=1", cmd_done); end
    tick;
    exp_count = exp_count + 16'd1;
    checks++; if (cmd_count !== exp_count) begin errors++; $display("FAIL foreign_count got=%h exp=%h", cmd_count, exp_count); end
  endtask

  task automatic test_nop_and_error;
    opcode = 6'b000000; cmd_valid = 1'b1;
    tick; cmd_valid = 1'b0;
    checks++; if ({cmd_done, cmd_error, engine_start} !== 6'b100000) begin
      errors++; $display("FAIL nop_done got=%b exp=100000", {cmd_done, cmd_error, engine_start}); end
    tick;
    exp_count = exp_count + 16'd1;
    checks++; if ({cmd_ready, cmd_count} !== {1'b1, exp_count}) begin
      errors++; $display("FAIL nop_count got=%b/%h exp=1/%h", cmd_ready, cmd_count, exp_count); end
    opcode = 6'b100101; cmd_valid = 1'b1;
    tick; cmd_valid = 1'b0;
    checks++; if ({cmd_error, cmd_done, engine_start} !== 6'b100000) begin
      errors++; $display("FAIL err_unmapped got=%b exp=100000", {cmd_error, cmd_done, engine_start}); end
    tick;
    checks++; if ({cmd_ready, cmd_error, cmd_count} !== {2'b10, exp_count}) begin
      errors++; $display("FAIL err_count got=%b%b/%h exp=10/%h", cmd_ready, cmd_error, cmd_count, exp_count); end
    opcode = 6'b011000; cmd_valid = 1'b1;
    tick; cmd_valid = 1'b0;
    checks++; if (cmd_error !== 1'b1) begin errors++; $display("FAIL err_prefix got=%b exp=1", cmd_error); end
    tick;
  endtask

  task automatic test_back_to_back;
    opcode = 6'b100000; target_way = 4'b0001; cmd_valid = 1'b1;
    tick; cmd_valid = 1'b0; // START
    last_step = 4'b0001;    // seen while in START
    tick;                   // RUN
    last_step = '0;
    checks++; if ({cmd_done, pm_pcommand} !== {1'b0, 8'hA0}) begin
      errors++; $display("FAIL start_laststep_ignored got=%b/%h exp=0/a0", cmd_done, pm_pcommand); end
    last_step = 4'b0001;
    tick;                   // DONE
    last_step = '0;
    opcode = 6'b100011; target_way = 4'b1000; cmd_valid = 1'b1;
    checks++; if (cmd_done !== 1'b1) begin errors++; $display("FAIL b2b_done1 got=%b exp=1", cmd_done); end
    tick;                   // IDLE, second command accepted at this cycle
    exp_count = exp_count + 16'd1;
    checks++; if ({cmd_ready, engine_start} !== 5'b10000) begin
      errors++; $display("FAIL b2b_idle got=%b exp=10000", {cmd_ready, engine_start}); end
    tick; cmd_valid = 1'b0;
    checks++; if ({engine_start, pm_pcommand, pm_way} !== {4'b1000, 8'hA3, 4'b1000}) begin
      errors++; $display("FAIL b2b_start2 got=%b/%h/%b exp=1000/a3/1000", engine_start, pm_pcommand, pm_way); end
    tick;
    last_step = 4'b1000;
    tick; last_step = '0;
    tick;
    exp_count = exp_count + 16'd1;
    checks++; if (cmd_count !== exp_count) begin errors++; $display("FAIL b2b_count got=%h exp=%h", cmd_count, exp_count); end
  endtask

  task automatic test_count_wrap;
    force dut.oCMDCount = 16'hFFFE;
    #1;
    release dut.oCMDCount;
    opcode = 6'b000000; cmd_valid = 1'b1;
    tick; tick; cmd_valid = 1'b0;
    checks++; if (cmd_count !== 16'hFFFF) begin errors++; $display("FAIL wrap_ffff got=%h exp=ffff", cmd_count); end
    cmd_valid = 1'b1;
    tick; tick; cmd_valid = 1'b0;
    checks++; if (cmd_count !== 16'h0000) begin errors++; $display("FAIL wrap_zero got=%h exp=0000", cmd_count); end
    exp_count = 16'h0000;
  endtask

  task automatic test_watchdog;
    opcode = 6'b100000; target_way = 4'b0010; cmd_valid = 1'b1;
    tick; cmd_valid = 1'b0; // START (T+1)
    tick;                   // first RUN cycle (T+2)
    for (int i = 0; i < 7; i++) tick; // T+9, eighth RUN cycle
    checks++; if ({cmd_timeout, cmd_ready} !== 2'b00) begin
      errors++; $display("FAIL wd_before_limit got=%b exp=00", {cmd_timeout, cmd_ready}); end
    tick;                   // T+10
`ifdef NPCG_BCMD_WATCHDOG_EN
    checks++; if ({cmd_timeout, cmd_ready, cmd_done} !== 3'b110) begin
      errors++; $display("FAIL wd_timeout got=%b exp=110", {cmd_timeout, cmd_ready, cmd_done}); end
    checks++; if ({pm_pcommand, cmd_count} !== {8'h00, exp_count}) begin
      errors++; $display("FAIL wd_idle got=%h/%h exp=00/%h", pm_pcommand, cmd_count, exp_count); end
    tick;
    checks++; if (cmd_timeout !== 1'b0) begin errors++; $display("FAIL wd_pulse_once got=%b exp=0", cmd_timeout); end
`else
    for (int i = 0; i < 10; i++) tick;
    checks++; if ({cmd_timeout, cmd_ready, pm_pcommand} !== {2'b00, 8'hA0}) begin
      errors++; $display("FAIL wd_absent got=%b/%h exp=00/a0", {cmd_timeout, cmd_ready}, pm_pcommand); end
    last_step = 4'b0001;
    tick; last_step = '0;
    tick;
    exp_count = exp_count + 16'd1;
    checks++; if (cmd_count !== exp_count) begin errors++; $display("FAIL wd_absent_count got=%h exp=%h", cmd_count, exp_count); end
`endif
  endtask

  task automatic test_reset_mid;
    opcode = 6'b100011; target_way = 4'b1111; cmd_valid = 1'b1;
    tick; cmd_valid = 1'b0;
    tick; tick; // RUN
    rst = 1'b1;
    #1;
    exp_count = 16'h0000;
    checks++; if ({cmd_ready, cmd_done, cmd_error, cmd_timeout, engine_start} !== 8'b1000_0000) begin
      errors++; $display("FAIL rstmid_flags got=%b exp=10000000", {cmd_ready, cmd_done, cmd_error, cmd_timeout, engine_start}); end
    checks++; if ({pm_pcommand, pm_option, pm_way, pm_num, cmd_count} !== {8'h00, 3'b000, 4'b0000, 16'h1234, exp_count}) begin
      errors++; $display("FAIL rstmid_pm got=%h/%h/%b/%h/%h exp=00/0/0000/1234/0000", pm_pcommand, pm_option, pm_way, pm_num, cmd_count); end
    tick;
    rst = 1'b0;
    tick;
    checks++; if ({cmd_ready, pm_pcommand} !== {1'b1, 8'h00}) begin
      errors++; $display("FAIL rstmid_after got=%b/%h exp=1/00", cmd_ready, pm_pcommand); end
  endtask

  initial begin
    test_reset;
    test_engine_cmd;
    test_foreign_laststep;
    test_nop_and_error;
    test_back_to_back;
    test_count_wrap;
    test_watchdog;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/npcg_toggle_bcmd_scheduler.md
# npcg_toggle_bcmd_scheduler

Blocking-command scheduler for the NPCG_Toggle layer. Accepts one command at a time from the dispatcher, decodes its opcode to one of NumberOfEngines blocking-command engines, pulses that engine's start, and grants it the primitive-manager (PM) command bus until it reports its last step. When no engine holds the grant, it drives the idle constants onto the PM bus.

## Interface
- NumberOfWays, 4, NAND ways; width of the target-way mask
- NumberOfEngines, 4, blocking-command engines; max 8
- WatchdogLimit, 16'hFFFF, RUN cycles before timeout (watchdog build only)

Ports:
- iSystemClock  in  1  system clock
- iReset  in  1  asynchronous, active-high reset
- iCMDValid  in  1  dispatcher command valid
- oCMDReady  out  1  scheduler can accept a command
- iOpcode  in  6  command opcode
- iTargetWay  in  NumberOfWays  way mask; latched with the command
- oEngineStart  out  NumberOfEngines  one-hot, one-cycle start pulse
- iEngineLastStep  in  NumberOfEngines  per-engine completion pulse
- iEnginePMBus  in  NumberOfEngines*27  packed per-engine {PCommand[7:0], PCommandOption[2:0], NumOfData[15:0]}; engine 0 in LSBs
- oPM_PCommand  out  8  granted PCommand
- oPM_PCommandOption  out  3  granted option
- oPM_TargetWay  out  NumberOfWays  latched way mask while granted
- oPM_NumOfData  out  16  granted data count
- oCMDDone  out  1  one-cycle completion pulse
- oCMDError  out  1  one-cycle unmapped-opcode pulse
- oCMDTimeout  out  1  one-cycle watchdog pulse
- oCMDCount  out  16  completed-command counter

## Operation
- States: IDLE, START, RUN, DONE, ERR.
- IDLE: oCMDReady=1. On iCMDValid, latch iOpcode and iTargetWay, then decode:
  - 6'b000000 (NOP) -> DONE
  - iOpcode[5:3]==3'b100 and iOpcode[2:0] < NumberOfEngines -> engine index = iOpcode[2:0]; go to START
  - anything else -> ERR
- START: oEngineStart[index]=1 for exactly one cycle; go to RUN.
- RUN: wait for iEngineLastStep[index], then go to DONE. LastStep from any other engine is ignored.
- DONE: oCMDDone=1; oCMDCount increments modulo 2^16 (0xFFFF wraps to 0x0000); go to IDLE.
- ERR: oCMDError=1; counter unchanged; go to IDLE.
- PM bus:
  - In START and RUN: the indexed engine's slice of iEnginePMBus is muxed to the PM outputs, and oPM_TargetWay carries the latched way mask.
  - Otherwise: idle constants PCommand 8'h00, option 3'b000, way all-zero, NumOfData 16'h1234.
- oCMDReady=0 in every state except IDLE. iCMDValid outside IDLE is ignored.
- Reset, including mid-command: state IDLE; all pulses 0; oCMDCount 0; latched index, opcode and way 0; PM outputs at idle constants; oCMDReady 1 once reset is released.

## Timing
- State and latched fields are registered. Outputs decode from registered state only, with no input-to-output combinational path except the iEnginePMBus mux.
- Command accepted at cycle T:
  - engine command: oEngineStart at T+1; RUN from T+2
  - NOP: oCMDDone at T+1
  - unmapped opcode: oCMDError at T+1
- Engine completion: iEngineLastStep sampled high in RUN at cycle K -> oCMDDone at K+1, oCMDReady at K+2.
- LastStep asserted during START is ignored. Engines guarantee at least one cycle of latency.
- Minimum back-to-back spacing for engine commands is 4 cycles. NOP and error commands take 2 cycles.

## Configuration
- NPCG_BCMD_WATCHDOG_EN defined:
  - A 16-bit counter clears on entering RUN and increments each RUN cycle.
  - When it reaches WatchdogLimit without a LastStep: oCMDTimeout pulses for one cycle, the counter is not incremented, and the state returns to IDLE.
  - LastStep and limit in the same cycle: LastStep wins.
- Not defined: no counter is built, oCMDTimeout is tied 0, and RUN waits indefinitely.

## Structure
- Shared package npcg_toggle_bcmd_pkg holds:
  - state encoding
  - NOP opcode, engine opcode prefix 3'b100
  - PM slice width 27 and field offsets
  - idle constants (PCommand 8'h00, NumOfData 16'h1234)
- One sub-module: npcg_toggle_bcmd_pm_mux, which selects and unpacks the granted iEnginePMBus slice, or outputs the idle constants when not granted.

## Test plan
- Reset, then idle: oCMDReady=1, oPM_NumOfData=16'h1234, oPM_PCommand=8'h00, oCMDCount=0.
- Opcode 6'b100010 with way 4'b0100 accepted at T -> oEngineStart=4'b0100 at T+1. Engine 2 PM slice is visible from T+1. iEngineLastStep[2] at T+5 -> oCMDDone at T+6, oCMDCount=1, oCMDReady at T+7.
- During RUN on engine 1, pulse iEngineLastStep[3] and iCMDValid -> no state change, no done, command not accepted.
- Opcode 6'b000000 -> oCMDDone at T+1 with no engine start. Opcode 6'b100101 with NumberOfEngines=4 -> oCMDError at T+1 and the counter is unchanged.
- Preload oCMDCount to 16'hFFFF via 65535 NOPs, then one more NOP -> oCMDCount=16'h0000.
- With NPCG_BCMD_WATCHDOG_EN and WatchdogLimit=8, start engine 0 and never complete it -> oCMDTimeout after 8 RUN cycles, then IDLE. Separately, assert iReset during RUN -> all outputs at reset values.
